// File: rtl/rob_id_remap_table.sv
// Original-ID to unique-ID remapper. Each bound original ID owns one row; each
// request takes the row's tail column and requests retire in order from the head.

module rob_id_remap_row #(
  parameter int ID_WIDTH = 4,
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alloc_en_i,
  input  logic [ID_WIDTH-1:0]                alloc_id_i,
  input  logic                               free_en_i,
  output logic                               bound_o,
  output logic [ID_WIDTH-1:0]                id_o,
  output logic [COL_W-1:0]                   head_o,
  output logic [COL_W-1:0]                   tail_o,
  output logic [COL_W:0]                     cnt_o,
  output logic [NUM_COLS-1:0]                slot_vld_o,
  output logic [NUM_COLS-1:0][ID_WIDTH-1:0]  slot_id_o
);
  logic                              bound_q, bound_d;
  logic [ID_WIDTH-1:0]               id_q;
  logic [COL_W-1:0]                  head_q, head_d, tail_q, tail_d;
  logic [COL_W:0]                    cnt_q, cnt_d;
  logic [NUM_COLS-1:0]               vld_q, vld_d;
  logic [NUM_COLS-1:0][ID_WIDTH-1:0] slot_id_q;

  always_comb begin
    bound_d = bound_q;
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q + (COL_W+1)'(alloc_en_i) - (COL_W+1)'(free_en_i);
    if (alloc_en_i) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
      bound_d       = 1'b1;
    end
    if (free_en_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    // Last request retired with no refill this cycle: release the row.
    if (free_en_i && !alloc_en_i && cnt_q == (COL_W+1)'(1)) begin
      bound_d = 1'b0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bound_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
    end else begin
      bound_q <= bound_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && alloc_en_i) begin
      slot_id_q[tail_q] <= alloc_id_i;
      if (!bound_q) id_q <= alloc_id_i;
    end
  end

  assign bound_o    = bound_q;
  assign id_o       = id_q;
  assign head_o     = head_q;
  assign tail_o     = tail_q;
  assign cnt_o      = cnt_q;
  assign slot_vld_o = vld_q;
  assign slot_id_o  = slot_id_q;
endmodule

module rob_id_remap_table #(
  parameter int ID_WIDTH = 4,
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int ROW_W    = $clog2(NUM_ROWS),
  parameter int COL_W    = $clog2(NUM_COLS),
  parameter int CNT_W    = $clog2(NUM_ROWS*NUM_COLS+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [ID_WIDTH-1:0] alloc_orig_id,
  output logic                alloc_ready,
  output logic [ID_WIDTH-1:0] alloc_uid,
  input  logic                free_valid,
  input  logic [ID_WIDTH-1:0] free_uid,
  output logic [ID_WIDTH-1:0] free_orig_id,
  output logic                free_err,
  input  logic [ID_WIDTH-1:0] query_orig_id,
  output logic                query_hit,
  output logic [ID_WIDTH-1:0] query_uid,
  output logic [CNT_W-1:0]    outstanding,
  output logic                full,
  output logic                empty
);
  localparam logic [COL_W:0] ROW_CAP = (COL_W+1)'(NUM_COLS);
  localparam logic [CNT_W-1:0] TOT_CAP = CNT_W'(NUM_ROWS*NUM_COLS);

  logic [NUM_ROWS-1:0]                             row_bound;
  logic [NUM_ROWS-1:0][ID_WIDTH-1:0]               row_id;
  logic [NUM_ROWS-1:0][COL_W-1:0]                  row_head, row_tail;
  logic [NUM_ROWS-1:0][COL_W:0]                    row_cnt;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]               slot_vld;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][ID_WIDTH-1:0] slot_id;
  logic [NUM_ROWS-1:0]                             row_alloc, row_free;

  logic             a_hit, a_free_any, q_hit;
  logic [ROW_W-1:0] a_hit_row, a_free_row, q_row, sel_row, f_row;
  logic [COL_W-1:0] f_col;
  logic             alloc_fire, free_ok;
  logic [CNT_W-1:0] outst_q, outst_d;

  // Rows are one-hot per original ID, so a downward scan picks the single
  // match, and the lowest unbound row for a fresh binding.
  always_comb begin
    a_hit      = 1'b0;
    a_hit_row  = '0;
    a_free_any = 1'b0;
    a_free_row = '0;
    q_hit      = 1'b0;
    q_row      = '0;
    for (int r = NUM_ROWS-1; r >= 0; r--) begin
      if (!row_bound[r]) begin
        a_free_any = 1'b1;
        a_free_row = ROW_W'(r);
      end
      if (row_bound[r] && row_id[r] == alloc_orig_id) begin
        a_hit     = 1'b1;
        a_hit_row = ROW_W'(r);
      end
      if (row_bound[r] && row_id[r] == query_orig_id) begin
        q_hit = 1'b1;
        q_row = ROW_W'(r);
      end
    end
  end

  assign sel_row     = a_hit ? a_hit_row : a_free_row;
  assign alloc_ready = !rst && (a_hit ? (row_cnt[a_hit_row] < ROW_CAP) : a_free_any);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_uid   = ID_WIDTH'({sel_row, row_tail[sel_row]});

  assign f_row        = free_uid[ROW_W+COL_W-1:COL_W];
  assign f_col        = free_uid[COL_W-1:0];
  assign free_err     = free_valid && (!slot_vld[f_row][f_col] || f_col != row_head[f_row]);
  assign free_ok      = free_valid && !free_err && !rst;
  assign free_orig_id = slot_id[f_row][f_col];

  assign query_hit = q_hit;
  assign query_uid = q_hit ? ID_WIDTH'({q_row, row_head[q_row]}) : '0;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign row_alloc[r] = alloc_fire && sel_row == ROW_W'(r);
    assign row_free[r]  = free_ok && f_row == ROW_W'(r);

    rob_id_remap_row #(
      .ID_WIDTH (ID_WIDTH),
      .NUM_COLS (NUM_COLS),
      .COL_W    (COL_W)
    ) u_row (
      .clk        (clk),
      .rst        (rst),
      .alloc_en_i (row_alloc[r]),
      .alloc_id_i (alloc_orig_id),
      .free_en_i  (row_free[r]),
      .bound_o    (row_bound[r]),
      .id_o       (row_id[r]),
      .head_o     (row_head[r]),
      .tail_o     (row_tail[r]),
      .cnt_o      (row_cnt[r]),
      .slot_vld_o (slot_vld[r]),
      .slot_id_o  (slot_id[r])
    );
  end

  assign outst_d = outst_q + CNT_W'(alloc_fire) - CNT_W'(free_ok);

  always_ff @(posedge clk) begin
    if (rst) outst_q <= '0;
    else     outst_q <= outst_d;
  end

  assign outstanding = outst_q;
  assign full        = outst_q == TOT_CAP;
  assign empty       = outst_q == '0;
endmodule

// File: doc/rob_id_remap_table.md
Name: rob_id_remap_table

Overview:
- Next-generation ID remapper for the ROB front end; replaces the single-entry grant-style allocator.
- Each original AXI ID is bound to one row while it has requests outstanding. Each request gets a unique ID (uid) = {row, col}.
- Adds valid/ready handshakes, per-row in-order tracking (head/tail), free-order checking with an error flag, and an oldest-outstanding query port for the reorder logic.
- Rows and columns are independently parametrised.

Parameters:
- ID_WIDTH, 4, width of original ID and of uid.
- NUM_ROWS, 4, number of concurrently bound original IDs; power of two, >=2.
- NUM_COLS, 4, max outstanding requests per original ID; power of two, >=2.
- Derived: ROW_W = clog2(NUM_ROWS), COL_W = clog2(NUM_COLS), CNT_W = clog2(NUM_ROWS*NUM_COLS+1).
- Constraint: ROW_W+COL_W <= ID_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- alloc_valid  in  1  allocation request.
- alloc_orig_id  in  ID_WIDTH  original ID to remap.
- alloc_ready  out  1  allocation can be accepted this cycle.
- alloc_uid  out  ID_WIDTH  uid assigned; zero-extended {row,col}; valid when alloc_valid&alloc_ready.
- free_valid  in  1  release request.
- free_uid  in  ID_WIDTH  uid being released.
- free_orig_id  out  ID_WIDTH  original ID stored at free_uid (combinational lookup).
- free_err  out  1  free_valid with a slot that is not valid or not the row head.
- query_orig_id  in  ID_WIDTH  original ID to look up.
- query_hit  out  1  query_orig_id is bound to a row.
- query_uid  out  ID_WIDTH  uid of the oldest outstanding request of query_orig_id; 0 when no hit.
- outstanding  out  CNT_W  total valid slots.
- full  out  1  outstanding == NUM_ROWS*NUM_COLS.
- empty  out  1  outstanding == 0.

Behaviour:
- State per row: bound bit, bound orig ID, head ptr (COL_W), tail ptr (COL_W), count (COL_W+1 bits).
- State per slot: valid bit and stored orig ID.
- Reset: all rows unbound; head, tail, count = 0; all slot valid bits = 0; outstanding = 0.
- Reset outputs: alloc_ready=0 while rst is high; after reset, alloc_ready=1, empty=1, full=0, free_err=0, query_hit=0.
- Stored orig IDs need no reset.
- Reset asserted mid-operation clears all state in the next edge; any alloc or free in that cycle is dropped.
- Row select, from current registered state only:
  - If a bound row's orig ID equals alloc_orig_id, use that row (hit).
  - Otherwise use the lowest-index unbound row.
- alloc_ready = !rst & ((hit & count<NUM_COLS) | (!hit & any unbound row)). It does not depend on free_valid.
- Alloc fire (alloc_valid & alloc_ready):
  - alloc_uid = {row, tail}.
  - Set the slot valid bit and store alloc_orig_id in the slot.
  - tail+1 (wraps modulo NUM_COLS); count+1.
  - If the row was unbound: bind it and load the orig ID.
- Same orig ID never spans two rows. A full row stalls that ID (alloc_ready=0) even if other rows are free.
- Free, combinational check: row = free_uid[ROW_W+COL_W-1:COL_W], col = free_uid[COL_W-1:0].
  - free_err = free_valid & (!slot valid | col != head of row).
  - On an erroneous free: no state change.
- Legal free: clear the slot valid bit; head+1 (wraps); count-1.
  - If count becomes 0: unbind the row and reset head and tail to 0.
- Simultaneous alloc and free:
  - Both take effect in the same cycle.
  - outstanding is net unchanged.
  - If both hit the same row: count is unchanged, the row stays bound even if its count was 1, and the tail advances.
  - A row unbound by a free this cycle cannot be chosen by an alloc in the same cycle.
- Query: query_hit and query_uid = {row, head} are combinational from current state.
- Latency: alloc_uid, free_orig_id, free_err and query outputs are combinational. All state updates at the next posedge.

Test Plan:
- Reset, then alloc 0x7, 0x7, 0x7, 0xA -> alloc_uid 0x0, 0x1, 0x2, 0x4; outstanding=4; query 0x7 -> hit=1, uid=0x0.
- Alloc 0x7 four times -> uids 0x0..0x3, then alloc_ready=0 for 0x7; alloc 0x3 -> ready=1, uid=0x4.
- After uids 0x0, 0x1 for 0x7:
  - free 0x1 -> free_err=1, outstanding unchanged.
  - free 0x0 -> free_err=0, free_orig_id=0x7; query 0x7 -> uid 0x1.
- Row 0 holds only 0x0 (orig 0x7); same cycle alloc 0x7 and free 0x0 -> alloc_uid=0x1, row stays bound, outstanding unchanged.
- Wrap: for orig 0x5, alloc 4 (0x0..0x3), free 0x0, 0x1, alloc 2 -> uids 0x0, 0x1 (tail wrapped); query uid=0x2.
- Bind 0x1, 0x2, 0x3, 0x4 (one alloc each), then alloc 0x9 -> alloc_ready=0.
  - Assert rst for one cycle mid-traffic -> empty=1, outstanding=0, all query_hit=0.
  - Next alloc 0x9 -> uid 0x0.
